// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: prioritizes interrupt, exception and ERET,
// pulses the CP0 update, then drives flush and the fetch redirect handshake.
// Optional: define CP0_EXC_CNT_EN to add the exc_cnt exception counter output.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  hw_int,
    input  logic        timer_int,
    input  logic [1:0]  sw_ip,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [31:0] epc_in,
    input  logic        cmt_valid,
    input  logic        cmt_exc,
    input  logic [4:0]  cmt_exccode,
    input  logic [31:0] cmt_pc,
    input  logic        cmt_is_ds,
    input  logic        cmt_eret,
    input  logic        redirect_ready,
`ifdef CP0_EXC_CNT_EN
    output logic [31:0] exc_cnt,
`endif
    output logic        busy,
    output logic        exception,
    output logic        eret_op,
    output logic [4:0]  exc_code,
    output logic [31:0] epc_out,
    output logic        bd_out,
    output logic [5:0]  cause_ip_hw,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HW_W   = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_FLUSH,
        S_REDIRECT
    } state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  fcnt_q, fcnt_d;
    logic [SYNC_STAGES-1:0][HW_W-1:0]  hw_sync_q, hw_sync_d;

    logic              busy_q, busy_d;
    logic              exception_q, exception_d;
    logic              eret_op_q, eret_op_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [DATA_W-1:0] epc_out_q, epc_out_d;
    logic              bd_out_q, bd_out_d;
    logic [HW_W-1:0]   cause_ip_hw_q, cause_ip_hw_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    logic [7:0]        ip_c;
    logic              int_take_c;
    logic              accept_c;
    logic              take_exc_c;
    logic              take_eret_c;

    // Interrupt qualification and request arbitration (interrupt > exception > ERET)
    always_comb begin
        ip_c        = {hw_sync_q[SYNC_STAGES-1][5] | timer_int,
                       hw_sync_q[SYNC_STAGES-1][4:0], sw_ip};
        int_take_c  = status_ie & ~status_exl & (|(ip_c & status_im));
        accept_c    = (state_q == S_IDLE) & cmt_valid & (int_take_c | cmt_exc | cmt_eret);
        take_exc_c  = accept_c & (int_take_c | cmt_exc);
        take_eret_c = accept_c & ~int_take_c & ~cmt_exc & cmt_eret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // Commit cycle already counts as the first flush cycle
                if (FLUSH_CYCLES <= 1) begin
                    state_d = S_REDIRECT;
                end else begin
                    state_d = S_FLUSH;
                    fcnt_d  = CNT_W'(FLUSH_CYCLES - 2);
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) state_d = S_REDIRECT;
                else              fcnt_d  = fcnt_q - CNT_W'(1);
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the state being entered
    always_comb begin
        hw_sync_d        = {hw_sync_q[SYNC_STAGES-2:0], hw_int};
        cause_ip_hw_d    = {hw_sync_q[SYNC_STAGES-2][5] | timer_int,
                            hw_sync_q[SYNC_STAGES-2][4:0]};
        busy_d           = (state_d != S_IDLE);
        flush_d          = (state_d == S_COMMIT) | (state_d == S_FLUSH);
        redirect_valid_d = (state_d == S_REDIRECT);
        exception_d      = take_exc_c;
        eret_op_d        = take_eret_c;
        exc_code_d       = exc_code_q;
        epc_out_d        = epc_out_q;
        bd_out_d         = bd_out_q;
        redirect_pc_d    = redirect_pc_q;
        if (take_exc_c) begin
            exc_code_d = int_take_c ? 5'd0 : cmt_exccode;
            epc_out_d  = cmt_is_ds ? (cmt_pc - DATA_W'(4)) : cmt_pc;
            bd_out_d   = cmt_is_ds;
        end
        if (accept_c) begin
            redirect_pc_d = take_eret_c ? epc_in : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_sync_q        <= '0;
            cause_ip_hw_q    <= '0;
            busy_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            exception_q      <= 1'b0;
            eret_op_q        <= 1'b0;
            exc_code_q       <= '0;
            epc_out_q        <= '0;
            bd_out_q         <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            hw_sync_q        <= hw_sync_d;
            cause_ip_hw_q    <= cause_ip_hw_d;
            busy_q           <= busy_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            exception_q      <= exception_d;
            eret_op_q        <= eret_op_d;
            exc_code_q       <= exc_code_d;
            epc_out_q        <= epc_out_d;
            bd_out_q         <= bd_out_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign busy           = busy_q;
    assign exception      = exception_q;
    assign eret_op        = eret_op_q;
    assign exc_code       = exc_code_q;
    assign epc_out        = epc_out_q;
    assign bd_out         = bd_out_q;
    assign cause_ip_hw    = cause_ip_hw_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef CP0_EXC_CNT_EN
    logic [DATA_W-1:0] exc_cnt_q, exc_cnt_d;

    // Counts exception pulses only; wraps naturally
    always_comb begin
        exc_cnt_d = exc_cnt_q + DATA_W'(exception_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exc_cnt_q <= '0;
        else        exc_cnt_q <= exc_cnt_d;
    end

    assign exc_cnt = exc_cnt_q;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: vector table of single transactions plus
// hand sequences for synchronizer latency, redirect back-pressure and async reset.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic        timer_int;
    logic [1:0]  sw_ip;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic [31:0] epc_in;
    logic        cmt_valid;
    logic        cmt_exc;
    logic [4:0]  cmt_exccode;
    logic [31:0] cmt_pc;
    logic        cmt_is_ds;
    logic        cmt_eret;
    logic        redirect_ready;
    logic        busy;
    logic        exception;
    logic        eret_op;
    logic [4:0]  exc_code;
    logic [31:0] epc_out;
    logic        bd_out;
    logic [5:0]  cause_ip_hw;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef CP0_EXC_CNT_EN
    logic [31:0] exc_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hw_int(hw_int), .timer_int(timer_int),
        .sw_ip(sw_ip), .status_ie(status_ie), .status_exl(status_exl),
        .status_im(status_im), .epc_in(epc_in), .cmt_valid(cmt_valid),
        .cmt_exc(cmt_exc), .cmt_exccode(cmt_exccode), .cmt_pc(cmt_pc),
        .cmt_is_ds(cmt_is_ds), .cmt_eret(cmt_eret), .redirect_ready(redirect_ready),
`ifdef CP0_EXC_CNT_EN
        .exc_cnt(exc_cnt),
`endif
        .busy(busy), .exception(exception), .eret_op(eret_op), .exc_code(exc_code),
        .epc_out(epc_out), .bd_out(bd_out), .cause_ip_hw(cause_ip_hw), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ie;
        logic        exl;
        logic [7:0]  im;
        logic [1:0]  sw;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic        eret;
        logic [31:0] epc;
        logic        x_exc;
        logic        x_eret;
        logic [4:0]  x_code;
        logic [31:0] x_epc;
        logic        x_bd;
        logic [31:0] x_rpc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hw_int = '0; timer_int = 1'b0; sw_ip = '0;
        status_ie = 1'b0; status_exl = 1'b0; status_im = '0; epc_in = '0;
        cmt_valid = 1'b0; cmt_exc = 1'b0; cmt_exccode = '0; cmt_pc = '0;
        cmt_is_ds = 1'b0; cmt_eret = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        tick();
        status_ie = v.ie; status_exl = v.exl; status_im = v.im; sw_ip = v.sw;
        cmt_exc = v.exc; cmt_exccode = v.code; cmt_pc = v.pc; cmt_is_ds = v.ds;
        cmt_eret = v.eret; epc_in = v.epc; cmt_valid = 1'b1;
        tick();
        chk({s, "_exception"}, 32'(exception), 32'(v.x_exc));
        chk({s, "_eret_op"}, 32'(eret_op), 32'(v.x_eret));
        chk({s, "_commit_flush"}, 32'(flush), 32'd1);
        chk({s, "_commit_busy"}, 32'(busy), 32'd1);
        chk({s, "_exc_code"}, 32'(exc_code), 32'(v.x_code));
        chk({s, "_epc_out"}, epc_out, v.x_epc);
        chk({s, "_bd_out"}, 32'(bd_out), 32'(v.x_bd));
        cmt_valid = 1'b0; cmt_exc = 1'b0; cmt_eret = 1'b0;
        tick();
        chk({s, "_flush2"}, 32'(flush), 32'd1);
        chk({s, "_pulse_gone"}, 32'(exception | eret_op), 32'd0);
        tick();
        chk({s, "_redir_valid"}, 32'(redirect_valid), 32'd1);
        chk({s, "_redir_flush"}, 32'(flush), 32'd0);
        chk({s, "_redir_pc"}, redirect_pc, v.x_rpc);
        redirect_ready = 1'b1;
        tick();
        chk({s, "_idle_busy"}, 32'(busy), 32'd0);
        chk({s, "_idle_rv"}, 32'(redirect_valid), 32'd0);
        clear_inputs();
    endtask

    initial begin
        logic [31:0] held_pc;
        // ie exl im sw exc code pc ds eret epc | x_exc x_eret x_code x_epc x_bd x_rpc
        vecs[0] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 5'h0C, 32'h80000204, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'h0C, 32'h80000200, 1'b1, 32'hBFC00380};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 5'h00, 32'h80000900, 1'b0, 1'b1, 32'h80001000,
                    1'b0, 1'b1, 5'h0C, 32'h80000200, 1'b1, 32'h80001000};
        vecs[2] = '{1'b1, 1'b0, 8'h01, 2'b01, 1'b0, 5'h00, 32'h80000300, 1'b0, 1'b1, 32'h80002000,
                    1'b1, 1'b0, 5'h00, 32'h80000300, 1'b0, 32'hBFC00380};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 2'b11, 1'b1, 5'h04, 32'h00000000, 1'b1, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'h04, 32'hFFFFFFFC, 1'b1, 32'hBFC00380};
        vecs[4] = '{1'b1, 1'b0, 8'h02, 2'b10, 1'b1, 5'h08, 32'h80000400, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'h00, 32'h80000400, 1'b0, 32'hBFC00380};
        vecs[5] = '{1'b1, 1'b0, 8'h01, 2'b10, 1'b1, 5'h0A, 32'h80000500, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'h0A, 32'h80000500, 1'b0, 32'hBFC00380};

        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_exc", 32'(exception), 32'd0);
`ifdef CP0_EXC_CNT_EN
        chk("rst_exc_cnt", exc_cnt, 32'd0);
`endif
        rst_n = 1'b1;

        // Pending interrupt without a committing instruction is not taken
        status_ie = 1'b1; status_im = 8'h01; sw_ip = 2'b01;
        tick(); tick(); tick();
        chk("noval_busy", 32'(busy), 32'd0);
        chk("noval_exc", 32'(exception), 32'd0);
        clear_inputs();

        // hw_int[0] through the synchronizer, then taken as an interrupt
        tick();
        status_ie = 1'b1; status_im = 8'h04; cmt_valid = 1'b1; cmt_pc = 32'h80000100;
        hw_int = 6'h01;
        tick();
        chk("sync_lat1", 32'(cause_ip_hw), 32'd0);
        chk("sync_noexc1", 32'(exception), 32'd0);
        tick();
        chk("sync_lat2", 32'(cause_ip_hw), 32'h01);
        chk("sync_noexc2", 32'(exception), 32'd0);
        tick();
        chk("hwint_exc", 32'(exception), 32'd1);
        chk("hwint_code", 32'(exc_code), 32'd0);
        chk("hwint_epc", epc_out, 32'h80000100);
        chk("hwint_bd", 32'(bd_out), 32'd0);
        chk("hwint_flush1", 32'(flush), 32'd1);
        cmt_valid = 1'b0; hw_int = '0; status_ie = 1'b0;
        tick();
        chk("hwint_flush2", 32'(flush), 32'd1);
        tick();
        chk("hwint_flush_off", 32'(flush), 32'd0);
        chk("hwint_rpc", redirect_pc, 32'hBFC00380);
        redirect_ready = 1'b1;
        tick();
        chk("hwint_idle", 32'(busy), 32'd0);
        clear_inputs();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Redirect back-pressure: commit request ignored while busy
        tick();
        cmt_valid = 1'b1; cmt_exc = 1'b1; cmt_exccode = 5'h0C; cmt_pc = 32'h80000600;
        tick();
        cmt_exccode = 5'h0D; cmt_pc = 32'h80000700;
        tick();
        tick();
        held_pc = 32'hBFC00380;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rv%0d", i), 32'(redirect_valid), 32'd1);
            chk($sformatf("bp_rpc%0d", i), redirect_pc, held_pc);
            chk($sformatf("bp_busy%0d", i), 32'(busy | (exception << 1)), 32'd1);
            tick();
        end
        chk("bp_code_held", 32'(exc_code), 32'h0C);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_noexc", 32'(exception), 32'd0);
        tick();
        chk("bp_new_exc", 32'(exception), 32'd1);
        chk("bp_new_code", 32'(exc_code), 32'h0D);
        chk("bp_new_epc", epc_out, 32'h80000700);
        cmt_valid = 1'b0; cmt_exc = 1'b0;
        tick();
        tick();
        redirect_ready = 1'b1;
        tick();
        chk("bp_done", 32'(busy), 32'd0);
        clear_inputs();

        // Asynchronous reset in the middle of FLUSH
        tick();
        cmt_valid = 1'b1; cmt_exc = 1'b1; cmt_exccode = 5'h0A; cmt_pc = 32'h80000800;
        tick();
        cmt_valid = 1'b0; cmt_exc = 1'b0;
        tick();
        chk("mid_flush", 32'(flush), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_code", 32'(exc_code), 32'd0);
        chk("arst_epc", epc_out, 32'd0);
        chk("arst_rpc", redirect_pc, 32'd0);
`ifdef CP0_EXC_CNT_EN
        chk("arst_exc_cnt", exc_cnt, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rv", 32'(redirect_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
